pipelined_addsub_rca: RTL and testbench
=======================================

// Module: pipelined_addsub_rca
// PURPOSE
//  Parametrised, pipelined ripple-carry adder/subtractor; successor to the fixed 64-bit structural RCA.
//  - Splits a WIDTH-bit add/sub into STAGES ripple slices, one slice per pipeline stage.
//  - Carries valid/ready flow control with full back-pressure.
//  - Feeds the datapath/ALU where a single-cycle 64-bit ripple chain misses timing.
// PARAMETERS
//  WIDTH   64  operand/result width in bits; WIDTH % STAGES == 0 (elaboration error otherwise)
//  STAGES  4   number of pipeline stages (1..WIDTH); slice width SW = WIDTH/STAGES
// PORTS
//  clk        in   1      single clock, rising edge
//  rst        in   1      synchronous, active-high reset
//  in_valid   in   1      a/b/c_in/sub valid this cycle
//  in_ready   out  1      block accepts input this cycle
//  a          in   WIDTH  operand A
//  b          in   WIDTH  operand B
//  c_in       in   1      carry-in (add) / borrow-in (sub)
//  sub        in   1      0: a+b+c_in   1: a-b-c_in
//  out_valid  out  1      sum/c_out/overflow valid
//  out_ready  in   1      downstream accepts result
//  sum        out  WIDTH  result, modulo 2^WIDTH
//  c_out      out  1      raw carry out of MSB (sub: 1 = no borrow)
//  overflow   out  1      two's-complement signed overflow
// BEHAVIOUR
//  Arithmetic:
//  - Effective B = sub ? ~b : b; effective carry-in = sub ? ~c_in : c_in.
//  - Hence sub computes a + ~b + !c_in = a - b - c_in.
//  - overflow = (A[MSB] == Beff[MSB]) && (sum[MSB] != A[MSB]).
//  Pipeline:
//  - Stage k (0..STAGES-1) ripples bits [k*SW +: SW] using the carry registered from stage k-1.
//  - Higher operand slices are delayed alongside; lower result slices are carried forward.
//  - Slices are aligned so each result is bit-exact to an unpipelined WIDTH-bit RCA.
//  - Each stage holds a valid bit. Latency = STAGES cycles from accepted input to out_valid, when not stalled.
//  - Throughput is 1 op/cycle.
//  Handshake:
//  - advance = !out_valid || out_ready; in_ready = advance (combinational from out_valid/out_ready only).
//  - Transfer in: in_valid && in_ready. Transfer out: out_valid && out_ready.
//  - advance=0: every stage register, including valid bits, holds.
//  - When stalled, sum/c_out/overflow stay stable while out_valid=1.
//  - Bubbles (in_valid=0 on advance) shift through as valid=0; data under valid=0 is don't-care.
//  - Simultaneous out transfer and in transfer in the same cycle is legal; no bubble is inserted.
//  Reset:
//  - rst=1 at a clock edge clears all stage valid bits, so out_valid=0.
//  - sum, c_out and overflow reset to 0.
//  - Reset mid-operation discards all in-flight ops; the first input accepted after reset appears STAGES cycles later.
//  - in_ready=1 during and after reset (out_valid=0).
//  STAGES=1:
//  - Single register stage, latency 1, same handshake.
//  Boundaries:
//  - a=b=all-ones, c_in=1, add: sum=all-ones, c_out=1.
//  - Carry must cross every slice boundary correctly.
// TESTING (WIDTH=64, STAGES=4 unless noted)
//  1. Carry chain: add a=64'hFFFF_FFFF_FFFF_FFFF, b=0, c_in=1.
//     -> after 4 cycles: sum=0, c_out=1, overflow=0.
//  2. Subtract/overflow: sub=1, a=64'h8000_0000_0000_0000, b=1, c_in=0.
//     -> sum=64'h7FFF_FFFF_FFFF_FFFF, c_out=1, overflow=1.
//     Also a=0, b=1 -> sum=all-ones, c_out=0.
//  3. Streaming: 100 back-to-back random ops with out_ready=1.
//     -> out_valid continuous from cycle 4.
//     -> results in order and match a golden model of a+b+c_in / a-b-c_in.
//  4. Back-pressure: out_ready=0 for 5 cycles while results are pending.
//     -> in_ready=0, outputs frozen, no result lost or duplicated.
//     -> on out_ready=1, results resume in order.
//  5. Reset mid-flight: 3 ops in the pipe, assert rst for 1 cycle.
//     -> out_valid=0 and sum=0 next cycle; the 3 ops never emerge.
//  6. Parametric: repeat 1-3 with WIDTH=32/STAGES=1 (latency 1) and WIDTH=16/STAGES=16 (latency 16).

Source files
------------

// File: rtl/pipelined_addsub_rca.sv
// Pipelined ripple-carry adder/subtractor: a WIDTH-bit add/sub split into STAGES
// ripple slices, one slice per pipeline stage, with valid/ready back-pressure.
module pipelined_addsub_rca #(
   parameter int WIDTH  = 64,
   parameter int STAGES = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             c_in,
   input  logic             sub,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] sum,
   output logic             c_out,
   output logic             overflow
);

   localparam int SW = WIDTH / STAGES;

   if (STAGES < 1 || STAGES > WIDTH || (WIDTH % STAGES) != 0) begin : g_param_check
      $error("pipelined_addsub_rca: WIDTH must be a multiple of STAGES, 1 <= STAGES <= WIDTH");
   end

   // One SW-bit ripple slice; returns {carry_out, sum_slice}.
   function automatic logic [SW:0] ripple_slice(input logic [SW-1:0] x,
                                                input logic [SW-1:0] y,
                                                input logic          ci);
      logic [SW-1:0] s;
      logic          c;
      c = ci;
      s = '0;
      for (int i = 0; i < SW; i++) begin
         s[i] = x[i] ^ y[i] ^ c;
         c    = (x[i] & y[i]) | (c & (x[i] ^ y[i]));
      end
      return {c, s};
   endfunction

   // Handshake: a transfer happens on a rising edge where valid && ready.
   // The whole pipe advances when the output slot is empty or being drained;
   // otherwise every stage (valid bits included) holds, so in_ready depends
   // only on out_valid/out_ready and never on in_valid.
   logic advance;
   assign advance  = !out_valid || out_ready;
   assign in_ready = advance;

   logic [WIDTH-1:0] b_eff;
   logic             c_eff;
   assign b_eff = sub ? ~b : b;
   assign c_eff = sub ? ~c_in : c_in;

   for (genvar k = 0; k < STAGES; k++) begin : g_stg
      // Stage k sees operand bits [WIDTH-1:k*SW]; it consumes the lowest SW of them.
      localparam int SRC_W = WIDTH - k * SW;

      logic [SRC_W-1:0]      src_a;
      logic [SRC_W-1:0]      src_b;
      logic                  src_c;
      logic                  src_v;
      logic [SW:0]           slice;
      logic [(k+1)*SW-1:0]   res_d;
      logic [(k+1)*SW-1:0]   res_q;
      logic                  cy_q;
      logic                  vld_q;

      if (k == 0) begin : g_src
         assign src_a = a;
         assign src_b = b_eff;
         assign src_c = c_eff;
         assign src_v = in_valid;
         assign res_d = slice[SW-1:0];
      end else begin : g_src
         assign src_a = g_stg[k-1].g_fwd.opa_q;
         assign src_b = g_stg[k-1].g_fwd.opb_q;
         assign src_c = g_stg[k-1].cy_q;
         assign src_v = g_stg[k-1].vld_q;
         assign res_d = {slice[SW-1:0], g_stg[k-1].res_q};
      end

      assign slice = ripple_slice(src_a[SW-1:0], src_b[SW-1:0], src_c);

      always_ff @(posedge clk) begin
         if (rst) begin
            vld_q <= 1'b0;
         end else if (advance) begin
            vld_q <= src_v;
         end
      end

      if (k < STAGES - 1) begin : g_fwd
         logic [SRC_W-SW-1:0] opa_q;
         logic [SRC_W-SW-1:0] opb_q;

         // Data under valid=0 is don't-care, so intermediate data needs no reset.
         always_ff @(posedge clk) begin
            if (advance) begin
               opa_q <= src_a[SRC_W-1:SW];
               opb_q <= src_b[SRC_W-1:SW];
               res_q <= res_d;
               cy_q  <= slice[SW];
            end
         end
      end else begin : g_last
         logic ovf_d;
         logic ovf_q;

         assign ovf_d = (src_a[SW-1] == src_b[SW-1]) && (slice[SW-1] != src_a[SW-1]);

         always_ff @(posedge clk) begin
            if (rst) begin
               res_q <= '0;
               cy_q  <= 1'b0;
               ovf_q <= 1'b0;
            end else if (advance) begin
               res_q <= res_d;
               cy_q  <= slice[SW];
               ovf_q <= ovf_d;
            end
         end

         assign sum       = res_q;
         assign c_out     = cy_q;
         assign overflow  = ovf_q;
         assign out_valid = vld_q;
      end
   end

endmodule

// File: tb/tb_pipelined_addsub_rca.sv
// Bench for pipelined_addsub_rca: three instances (64/4, 32/1, 16/16) exercised one
// at a time through a shared driver, with a scoreboard queue checked at the output.
module tb_pipelined_addsub_rca;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        rst;
   logic [1:0]  sel;
   logic        drv_valid;
   logic        drv_c_in;
   logic        drv_sub;
   logic        drv_ready;
   logic [63:0] drv_a;
   logic [63:0] drv_b;

   int n_checks = 0;
   int n_fail   = 0;
   logic [65:0] exp_q[$];

   logic        iv0, iv1, iv2;
   logic        ir0, ir1, ir2;
   logic        ov0, ov1, ov2;
   logic        co0, co1, co2;
   logic        of0, of1, of2;
   logic [63:0] s0;
   logic [31:0] s1;
   logic [15:0] s2;

   assign iv0 = drv_valid && (sel == 2'd0);
   assign iv1 = drv_valid && (sel == 2'd1);
   assign iv2 = drv_valid && (sel == 2'd2);

   pipelined_addsub_rca #(.WIDTH(64), .STAGES(4)) u_dut0 (
      .clk(clk), .rst(rst), .in_valid(iv0), .in_ready(ir0),
      .a(drv_a), .b(drv_b), .c_in(drv_c_in), .sub(drv_sub),
      .out_valid(ov0), .out_ready(drv_ready), .sum(s0), .c_out(co0), .overflow(of0));

   pipelined_addsub_rca #(.WIDTH(32), .STAGES(1)) u_dut1 (
      .clk(clk), .rst(rst), .in_valid(iv1), .in_ready(ir1),
      .a(drv_a[31:0]), .b(drv_b[31:0]), .c_in(drv_c_in), .sub(drv_sub),
      .out_valid(ov1), .out_ready(drv_ready), .sum(s1), .c_out(co1), .overflow(of1));

   pipelined_addsub_rca #(.WIDTH(16), .STAGES(16)) u_dut2 (
      .clk(clk), .rst(rst), .in_valid(iv2), .in_ready(ir2),
      .a(drv_a[15:0]), .b(drv_b[15:0]), .c_in(drv_c_in), .sub(drv_sub),
      .out_valid(ov2), .out_ready(drv_ready), .sum(s2), .c_out(co2), .overflow(of2));

   logic        cur_in_ready;
   logic        cur_out_valid;
   logic [65:0] cur_res;

   always_comb begin
      cur_in_ready  = 1'b0;
      cur_out_valid = 1'b0;
      cur_res       = '0;
      case (sel)
         2'd0: begin cur_in_ready = ir0; cur_out_valid = ov0; cur_res = {of0, co0, s0}; end
         2'd1: begin cur_in_ready = ir1; cur_out_valid = ov1; cur_res = {of1, co1, 32'd0, s1}; end
         2'd2: begin cur_in_ready = ir2; cur_out_valid = ov2; cur_res = {of2, co2, 48'd0, s2}; end
         default: ;
      endcase
   end

   function automatic int cfg_w(input logic [1:0] s);
      case (s)
         2'd0:    return 64;
         2'd1:    return 32;
         default: return 16;
      endcase
   endfunction

   function automatic int cfg_lat(input logic [1:0] s);
      case (s)
         2'd0:    return 4;
         2'd1:    return 1;
         default: return 16;
      endcase
   endfunction

   function automatic logic [63:0] width_mask(input int w);
      return (w == 64) ? 64'hFFFF_FFFF_FFFF_FFFF : ((64'd1 << w) - 64'd1);
   endfunction

   // Golden model: unsigned sum for sum/c_out, signed range check for overflow.
   function automatic logic [65:0] model(input logic [63:0] x, input logic [63:0] y,
                                         input logic ci, input logic sb, input int w);
      logic [63:0]        m, xm, ym, bm;
      logic [64:0]        t;
      logic signed [63:0] sx, sy;
      logic signed [66:0] wide, hi, lo;
      logic               ovf;
      m  = width_mask(w);
      xm = x & m;
      ym = y & m;
      bm = sb ? (~y & m) : ym;
      t  = {1'b0, xm} + {1'b0, bm} + {64'd0, (sb ? ~ci : ci)};
      sx = $signed(xm << (64 - w)) >>> (64 - w);
      sy = $signed(ym << (64 - w)) >>> (64 - w);
      wide = sb ? (67'(sx) - 67'(sy) - 67'(ci)) : (67'(sx) + 67'(sy) + 67'(ci));
      hi   = (67'sd1 <<< (w - 1)) - 67'sd1;
      lo   = -(67'sd1 <<< (w - 1));
      ovf  = (wide > hi) || (wide < lo);
      return {ovf, t[w], t[63:0] & m};
   endfunction

   task automatic check(input string tag, input logic [65:0] got, input logic [65:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   // Output side of the scoreboard: pop and compare on every output transfer.
   always @(negedge clk) begin
      if (!rst && cur_out_valid && drv_ready) begin
         check("out_expected", 66'(exp_q.size() != 0), 66'd1);
         if (exp_q.size() != 0) check("out_result", cur_res, exp_q.pop_front());
      end
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic send(input logic [63:0] x, input logic [63:0] y, input logic ci, input logic sb);
      int   tries;
      logic acc;
      drv_a     = x;
      drv_b     = y;
      drv_c_in  = ci;
      drv_sub   = sb;
      drv_valid = 1'b1;
      tries     = 0;
      #1;
      do begin
         acc = cur_in_ready;
         step();
         tries++;
      end while (!acc && tries < 50);
      if (acc) exp_q.push_back(model(x, y, ci, sb, cfg_w(sel)));
      else check("send_timeout", 66'(acc), 66'd1);
      drv_valid = 1'b0;
   endtask

   task automatic drain(input string tag);
      int n;
      n = 0;
      drv_valid = 1'b0;
      while (exp_q.size() != 0 && n < 200) begin
         step();
         n++;
      end
      check({tag, "_drained"}, 66'(exp_q.size()), 66'd0);
      repeat (3) step();
      check({tag, "_idle"}, 66'(cur_out_valid), 66'd0);
   endtask

   task automatic directed(input string tag, input logic [63:0] x, input logic [63:0] y,
                           input logic ci, input logic sb, input logic [65:0] want);
      int cyc;
      send(x, y, ci, sb);
      cyc = 1;
      while (!cur_out_valid && cyc < 40) begin
         step();
         cyc++;
      end
      check({tag, "_lat"}, 66'(cyc), 66'(cfg_lat(sel)));
      check({tag, "_res"}, cur_res, want);
      drain(tag);
   endtask

   task automatic stream(input string tag, input int n);
      for (int i = 0; i < n; i++) begin
         send({$urandom, $urandom}, {$urandom, $urandom},
              1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
         check({tag, "_ovalid"}, 66'(cur_out_valid), 66'((i + 1) >= cfg_lat(sel)));
      end
      drain(tag);
   endtask

   logic [63:0] m;
   logic [65:0] snap;

   initial begin
      rst       = 1'b1;
      sel       = 2'd0;
      drv_valid = 1'b0;
      drv_a     = '0;
      drv_b     = '0;
      drv_c_in  = 1'b0;
      drv_sub   = 1'b0;
      drv_ready = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      for (int s = 0; s < 3; s++) begin
         sel = 2'(s);
         #1;
         check("rst_in_ready", 66'(cur_in_ready), 66'd1);
      end
      rst = 1'b0;
      step();
      for (int s = 0; s < 3; s++) begin
         sel = 2'(s);
         #1;
         check("rst_out_valid", 66'(cur_out_valid), 66'd0);
         check("rst_res", cur_res, 66'd0);
      end

      for (int s = 0; s < 3; s++) begin
         sel = 2'(s);
         m   = width_mask(cfg_w(sel));
         directed("carry_chain",    m,              64'd0, 1'b1, 1'b0, {2'b01, 64'd0});
         directed("sub_ovf",        (m >> 1) + 1,   64'd1, 1'b0, 1'b1, {2'b11, m >> 1});
         directed("zero_minus_one", 64'd0,          64'd1, 1'b0, 1'b1, {2'b00, m});
         directed("all_ones",       m,              m,     1'b1, 1'b0, {2'b01, m});
         stream("stream", 100);
      end

      // Back-pressure on the 64/4 instance.
      sel = 2'd0;
      m   = width_mask(64);
      for (int i = 0; i < 6; i++) send({$urandom, $urandom}, {$urandom, $urandom}, 1'b1, 1'(i));
      drv_ready = 1'b0;
      drv_a     = 64'h1234_5678_9ABC_DEF0;
      drv_b     = 64'h0FED_CBA9_8765_4321;
      drv_valid = 1'b1;
      #1;
      snap = cur_res;
      check("stall_start_valid", 66'(cur_out_valid), 66'd1);
      repeat (5) begin
         step();
         check("stall_in_ready", 66'(cur_in_ready), 66'd0);
         check("stall_out_valid", 66'(cur_out_valid), 66'd1);
         check("stall_hold", cur_res, snap);
      end
      drv_ready = 1'b1;
      drv_valid = 1'b0;
      for (int i = 0; i < 4; i++) send({$urandom, $urandom}, {$urandom, $urandom}, 1'b0, 1'(i));
      drain("stall");

      // Reset with three ops in flight.
      for (int i = 0; i < 3; i++) send({$urandom, $urandom}, {$urandom, $urandom}, 1'b1, 1'b0);
      rst = 1'b1;
      #1;
      check("rst_mid_in_ready", 66'(cur_in_ready), 66'd1);
      step();
      rst = 1'b0;
      check("rst_mid_out_valid", 66'(cur_out_valid), 66'd0);
      check("rst_mid_res", cur_res, 66'd0);
      exp_q.delete();
      repeat (8) step();
      check("rst_mid_quiet", 66'(cur_out_valid), 66'd0);
      directed("post_rst", m, 64'd0, 1'b1, 1'b0, {2'b01, 64'd0});

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
